// File: rtl/sw_ctrl_if.sv
// Stopwatch button/output bundle between the panel inputs and the sw_ctrl stage.
// Lap signals exist only when SW_CTRL_LAP_EN is defined.
interface sw_ctrl_if;
  logic       btn_ss_ctl;
  logic       btn_clr_ctl;
  logic       tick_ctl;
  logic       clr_ctl;
  logic       run_ctl;
  logic [1:0] state_ctl;
`ifdef SW_CTRL_LAP_EN
  logic       btn_lap_ctl;
  logic       lap_ctl;

  modport master (
    output btn_ss_ctl, btn_clr_ctl, btn_lap_ctl,
    input  tick_ctl, clr_ctl, run_ctl, state_ctl, lap_ctl
  );
  modport slave (
    input  btn_ss_ctl, btn_clr_ctl, btn_lap_ctl,
    output tick_ctl, clr_ctl, run_ctl, state_ctl, lap_ctl
  );
`else
  modport master (
    output btn_ss_ctl, btn_clr_ctl,
    input  tick_ctl, clr_ctl, run_ctl, state_ctl
  );
  modport slave (
    input  btn_ss_ctl, btn_clr_ctl,
    output tick_ctl, clr_ctl, run_ctl, state_ctl
  );
`endif
endinterface

// File: rtl/sw_ctrl.sv
// Stopwatch control: 2-flop sync + debounce per button, IDLE/RUN/PAUSE FSM, 1 s prescaler.
// Press-to-state latency 2+DEB_CYCLES+1 cycles; no backpressure. Optional lap output: SW_CTRL_LAP_EN.
module sw_ctrl #(
  parameter int DEB_CYCLES = 250000,
  parameter int ONE_SEC    = 25000000,
  parameter int CNT_W      = 25
) (
  input  logic     clk_ctl,
  input  logic     rst_ctl,
  sw_ctrl_if.slave bus
);

`ifdef SW_CTRL_LAP_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(ONE_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  logic [NB-1:0]    w_raw;
  logic [NB-1:0]    r_s1;
  logic [NB-1:0]    r_s2;
  logic [NB-1:0]    r_deb;
  logic [NB-1:0]    r_deb_d;
  logic [DEB_W-1:0] r_cnt [NB];
  logic [NB-1:0]    w_evt;

  state_t           r_state;
  state_t           w_nxt;
  logic             r_run;
  logic             r_clr;
  logic             r_tick;
  logic             w_tick_nxt;
  logic [CNT_W-1:0] r_pre;
  logic [CNT_W-1:0] w_pre_nxt;
  logic             w_ss_evt;
  logic             w_clr_evt;

  assign w_raw[0] = bus.btn_ss_ctl;
  assign w_raw[1] = bus.btn_clr_ctl;
`ifdef SW_CTRL_LAP_EN
  assign w_raw[2] = bus.btn_lap_ctl;
`endif

  always_ff @(posedge clk_ctl or negedge rst_ctl) begin
    if (!rst_ctl) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_deb_d <= r_deb;
      // A level is accepted only after DEB_CYCLES consecutive mismatching samples.
      for (int i = 0; i < NB; i++) begin
        if (r_s2[i] != r_deb[i]) begin
          if (r_cnt[i] == DEB_MAX) begin
            r_deb[i] <= r_s2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + DEB_W'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_evt     = r_deb & ~r_deb_d;
  assign w_ss_evt  = w_evt[0];
  assign w_clr_evt = w_evt[1];

  always_comb begin
    w_nxt      = r_state;
    w_pre_nxt  = r_pre;
    w_tick_nxt = 1'b0;
    case (r_state)
      S_IDLE:  if (w_ss_evt) w_nxt = S_RUN;
      S_RUN:   if (w_ss_evt) w_nxt = S_PAUSE;
      S_PAUSE: if (w_ss_evt) w_nxt = S_RUN;
      default: w_nxt = S_IDLE;
    endcase
    if (w_clr_evt) w_nxt = S_IDLE;

    // A pause landing on the terminal count wins: the count holds and the tick is deferred.
    if (w_clr_evt || r_state == S_IDLE) begin
      w_pre_nxt = '0;
    end else if (r_state == S_RUN && !w_ss_evt) begin
      if (r_pre == PRE_MAX) begin
        w_pre_nxt  = '0;
        w_tick_nxt = 1'b1;
      end else begin
        w_pre_nxt = r_pre + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_ctl or negedge rst_ctl) begin
    if (!rst_ctl) begin
      r_state <= S_IDLE;
      r_run   <= 1'b0;
      r_clr   <= 1'b0;
      r_tick  <= 1'b0;
      r_pre   <= '0;
    end else begin
      r_state <= w_nxt;
      r_run   <= (w_nxt == S_RUN);
      r_clr   <= w_clr_evt;
      r_tick  <= w_tick_nxt;
      r_pre   <= w_pre_nxt;
    end
  end

  assign bus.tick_ctl  = r_tick;
  assign bus.clr_ctl   = r_clr;
  assign bus.run_ctl   = r_run;
  assign bus.state_ctl = r_state;

`ifdef SW_CTRL_LAP_EN
  logic r_lap;
  logic w_lap_nxt;

  always_comb begin
    w_lap_nxt = r_lap;
    if (w_clr_evt)                         w_lap_nxt = 1'b0;
    else if (r_state == S_RUN && w_evt[2]) w_lap_nxt = ~r_lap;
  end

  always_ff @(posedge clk_ctl or negedge rst_ctl) begin
    if (!rst_ctl) r_lap <= 1'b0;
    else          r_lap <= w_lap_nxt;
  end

  assign bus.lap_ctl = r_lap;
`endif

endmodule
